// File: rtl/systolic_feeder_if.sv
// Bundle between the tile loader / sequencer and the systolic feeder:
// the vector write handshake, the stream request and the array-facing outputs.
interface systolic_feeder_if #(
  parameter int width = 8,
  parameter int row   = 4,
  parameter int depth = 16
);
  logic                          wr_valid;
  logic [row-1:0][width-1:0]     wr_data;
  logic                          wr_ready;
  logic                          start;
  logic [row-1:0][width-1:0]     feature_out;
  logic [row-1:0]                en_out;
  logic [$clog2(depth+1)-1:0]    fill;
  logic                          busy;
  logic                          done;

  modport master (
    output wr_valid, wr_data, start,
    input  wr_ready, feature_out, en_out, fill, busy, done
  );

  modport slave (
    input  wr_valid, wr_data, start,
    output wr_ready, feature_out, en_out, fill, busy, done
  );
endinterface

// File: rtl/systolic_feeder.sv
// Feature-path feeder for the systolic array: buffers up to `depth` vectors,
// then streams them with a diagonal skew (lane r lags lane 0 by r cycles).
module systolic_feeder #(
  parameter int width = 8,
  parameter int row   = 4,
  parameter int depth = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  systolic_feeder_if.slave bus
);
  localparam int pw = $clog2(depth);
  localparam int fw = $clog2(depth + 1);
  localparam int cw = (row > 2) ? $clog2(row - 1) : 1;
  localparam logic [fw-1:0] fill_max   = fw'(depth);
  localparam logic [cw-1:0] drain_last = cw'((row > 1) ? row - 2 : 0);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
  typedef logic [row-1:0][width-1:0] vec_t;

  state_t        state, state_next;
  vec_t          mem [depth];
  vec_t          rd_vec;
  vec_t          lane_data;
  logic [row-1:0] lane_en;
  logic [pw-1:0] wr_ptr, rd_ptr;
  logic [fw-1:0] fill;
  logic [cw-1:0] drain_cnt;
  logic          wr_ready, wr_accept, issue, rd_stop, clear;

  assign wr_ready = (state == IDLE) && (fill < fill_max) && !bus.start && !rst_in;
  assign rd_vec   = mem[rd_ptr];
  // All vectors issued once the pointer reaches fill, or wraps for a full buffer.
  assign rd_stop  = ({1'b0, rd_ptr} == fill) || (rd_ptr == '0);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and control decode; vector 0 is issued on the start edge so
  // lane 0 presents it in the very next cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_next = state;
    issue      = 1'b0;
    clear      = 1'b0;
    wr_accept  = bus.wr_valid && wr_ready;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (fill != '0) begin
            state_next = STREAM;
            issue      = 1'b1;
          end else begin
            state_next = DONE;
          end
        end
      end
      STREAM: begin
        if (rd_stop) state_next = (row > 1) ? DRAIN : DONE;
        else         issue      = 1'b1;
      end
      DRAIN: begin
        if (drain_cnt == drain_last) state_next = DONE;
      end
      DONE: begin
        clear      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pointers, occupancy and drain counter.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      drain_cnt <= '0;
    end else begin
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        fill   <= '0;
      end else begin
        if (wr_accept) begin
          wr_ptr <= wr_ptr + pw'(1);
          fill   <= fill + fw'(1);
        end
        if (issue) rd_ptr <= rd_ptr + pw'(1);
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + cw'(1) : '0;
    end
  end

  // Vector storage.
  // NOTE: the buffer array has no reset; stale contents are unreachable
  // because fill and the pointers are cleared, and a resettable RAM would
  // force it into flops.
  always_ff @(posedge clk_in) begin
    if (wr_accept) mem[wr_ptr] <= bus.wr_data;
  end

  // Skew pipeline: lane r is a (r+1)-deep shift register of data and valid.
  for (genvar r = 0; r < row; r++) begin : g_lane
    logic [width-1:0] sd [r+1];
    logic [r:0]       sv;

    // Shift element r of the issued vector down this lane.
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        sv <= '0;
        for (int s = 0; s <= r; s++) sd[s] <= '0;
      end else begin
        sv[0] <= issue;
        sd[0] <= rd_vec[r];
        for (int s = 1; s <= r; s++) begin
          sv[s] <= sv[s-1];
          sd[s] <= sd[s-1];
        end
      end
    end

    assign lane_en[r]   = sv[r];
    assign lane_data[r] = sv[r] ? sd[r] : '0;
  end

  assign bus.wr_ready    = wr_ready;
  assign bus.feature_out = lane_data;
  assign bus.en_out      = lane_en;
  assign bus.fill        = fill;
  assign bus.busy        = (state == STREAM) || (state == DRAIN);
  assign bus.done        = (state == DONE);
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed + randomized bench for systolic_feeder. Expected lane activity is
// derived from the skew rule: lane r shows element r of vector k in cycle 1+k+r.
module tb_systolic_feeder;
  localparam int W = 8;
  localparam int R = 4;
  localparam int D = 16;

  typedef logic [R-1:0][W-1:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  vec_t model_q [$];

  systolic_feeder_if #(.width(W), .row(R), .depth(D)) bus ();

  systolic_feeder #(.width(W), .row(R), .depth(D)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int r = 0; r < R; r++) v[r] = W'($urandom);
    return v;
  endfunction

  // Enter the next cycle: just past the rising edge, inputs back to idle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
    bus.start    = 1'b0;
    bus.wr_data  = '0;
  endtask

  // Offer one vector; it is accepted only if the model says there is room.
  task automatic write_vec(input vec_t v);
    bit room;
    next_cycle();
    room = (model_q.size() < D);
    bus.wr_valid = 1'b1;
    bus.wr_data  = v;
    #1;
    check("wr_ready", 64'(bus.wr_ready), 64'(room));
    check("fill", 64'(bus.fill), 64'(model_q.size()));
    if (room) model_q.push_back(v);
  endtask

  // Pulse start (cycle 0) and check every output through cycle done+1.
  task automatic run_stream(input bit collide, input int poke_at);
    vec_t snap [$];
    int   n, done_c;
    next_cycle();
    bus.start = 1'b1;
    if (collide) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = rand_vec();
    end
    #1;
    check("wr_ready at start", 64'(bus.wr_ready), 64'(0));
    check("fill at start", 64'(bus.fill), 64'(model_q.size()));
    snap   = model_q;
    n      = snap.size();
    done_c = (n == 0) ? 1 : n + R;
    for (int c = 1; c <= done_c + 1; c++) begin
      logic [R-1:0] en_exp;
      vec_t         feat_exp;
      next_cycle();
      if (c <= done_c) begin
        if (c == poke_at) bus.start = 1'b1;
        bus.wr_valid = 1'($urandom_range(0, 1));
        bus.wr_data  = rand_vec();
      end
      #1;
      en_exp   = '0;
      feat_exp = '0;
      for (int r = 0; r < R; r++) begin
        int k;
        k = c - 1 - r;
        if (k >= 0 && k < n) begin
          en_exp[r]   = 1'b1;
          feat_exp[r] = snap[k][r];
        end
      end
      check($sformatf("en_out c%0d", c), 64'(bus.en_out), 64'(en_exp));
      check($sformatf("feature_out c%0d", c), 64'(bus.feature_out), 64'(feat_exp));
      check($sformatf("busy c%0d", c), 64'(bus.busy), 64'(n > 0 && c <= n + R - 1));
      check($sformatf("done c%0d", c), 64'(bus.done), 64'(c == done_c));
      if (c == done_c + 1) begin
        check("fill after done", 64'(bus.fill), 64'(0));
        check("wr_ready after done", 64'(bus.wr_ready), 64'(1));
      end else begin
        check($sformatf("wr_ready c%0d", c), 64'(bus.wr_ready), 64'(0));
      end
    end
    model_q.delete();
  endtask

  initial begin
    vec_t v;
    bus.wr_valid = 1'b0;
    bus.start    = 1'b0;
    bus.wr_data  = '0;

    // Reset values while rst is held.
    #12;
    check("rst en_out", 64'(bus.en_out), 64'(0));
    check("rst feature_out", 64'(bus.feature_out), 64'(0));
    check("rst fill", 64'(bus.fill), 64'(0));
    check("rst busy", 64'(bus.busy), 64'(0));
    check("rst done", 64'(bus.done), 64'(0));
    check("rst wr_ready", 64'(bus.wr_ready), 64'(0));
    #5 rst = 1'b0;
    next_cycle();
    #1;
    check("post-reset wr_ready", 64'(bus.wr_ready), 64'(1));
    check("post-reset fill", 64'(bus.fill), 64'(0));

    // Basic skewed stream with the fixed ramp vectors.
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < R; r++) v[r] = W'(4 * k + r + 1);
      write_vec(v);
    end
    run_stream(1'b0, 0);

    // Empty start.
    run_stream(1'b0, 0);

    // Full buffer plus one rejected write; a start pulse mid-stream is ignored.
    for (int i = 0; i < D + 1; i++) write_vec(rand_vec());
    run_stream(1'b0, 5);

    // start and wr_valid collide with two vectors buffered.
    for (int i = 0; i < 2; i++) write_vec(rand_vec());
    run_stream(1'b1, 0);

    // start during STREAM.
    for (int i = 0; i < 3; i++) write_vec(rand_vec());
    run_stream(1'b0, 2);

    // Reset mid-stream.
    for (int i = 0; i < 3; i++) write_vec(rand_vec());
    next_cycle();
    bus.start = 1'b1;
    next_cycle();
    #1;
    check("pre-reset en_out", 64'(bus.en_out), 64'(1));
    next_cycle();
    rst = 1'b1;
    #1;
    check("mid-reset en_out", 64'(bus.en_out), 64'(0));
    check("mid-reset feature_out", 64'(bus.feature_out), 64'(0));
    check("mid-reset busy", 64'(bus.busy), 64'(0));
    @(posedge clk);
    #4 rst = 1'b0;
    model_q.delete();
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      #1;
      check($sformatf("no done after reset c%0d", c), 64'(bus.done), 64'(0));
      check($sformatf("no en after reset c%0d", c), 64'(bus.en_out), 64'(0));
    end
    check("fill after reset", 64'(bus.fill), 64'(0));
    check("wr_ready after reset", 64'(bus.wr_ready), 64'(1));

    // Back-to-back tiles.
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 2; i++) write_vec(rand_vec());
      run_stream(1'b0, 0);
    end

    // Random tiles.
    for (int t = 0; t < 4; t++) begin
      int n;
      n = int'($urandom_range(1, D));
      for (int i = 0; i < n; i++) write_vec(rand_vec());
      run_stream(1'($urandom_range(0, 1)), int'($urandom_range(1, 4)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
